// File: rtl/relu_sram_sweeper_pkg.sv
// Shared types and helpers for the ReLU SRAM sweeper and its lane datapath.
package relu_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Index of the sign bit for a word of width w (two's complement or IEEE float).
  function automatic int unsigned sign_bit(input int unsigned w);
    return w - 1;
  endfunction

endpackage

// File: rtl/relu_sram_sweeper_relu_lane.sv
// Single-lane ReLU clip: any word with the sign bit set (including -0 and
// negative NaN) becomes zero. Purely combinational so it can be arrayed.
module relu_lane
  import relu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o,
  output logic         neg_o
);

  localparam int SB = sign_bit(W);

  assign neg_o = x_i[SB];
  assign y_o   = neg_o ? '0 : x_i;

endmodule

// File: rtl/relu_sram_sweeper.sv
// Sweeps a contiguous SRAM range: read a word, write back its ReLU at the
// destination range, two cycles per element. Addresses wrap mod bank depth.
module relu_sram_sweeper
  import relu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int Data_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   neg_cnt,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [Data_W-1:0] sram_wdata,
  input  logic [Data_W-1:0] sram_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   neg_q, neg_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;

  logic [Data_W-1:0] clip;
  logic              is_neg;

  relu_lane #(.W(Data_W)) u_lane (
    .x_i   (sram_rdata),
    .y_o   (clip),
    .neg_o (is_neg)
  );

  // Status outputs come straight from registered state.
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign neg_cnt = neg_q;

  // State register; async reset kills any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      neg_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      neg_q   <= neg_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  // Next-state and SRAM pin decode; IDLE/DONE leave the bank quiet.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    neg_d      = neg_q;
    src_d      = src_q;
    dst_d      = dst_q;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = len;
          idx_d   = '0;
          neg_d   = '0;
          state_d = (len == '0) ? DONE : RD;
        end
      end
      RD: begin
        sram_cs   = 1'b1;
        sram_addr = src_q + idx_q[ADDR_W-1:0];
        state_d   = WR;
      end
      WR: begin
        // Read data from the previous RD cycle is consumed here, never later.
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = dst_q + idx_q[ADDR_W-1:0];
        sram_wdata = clip;
        if (is_neg) neg_d = neg_q + 1'b1;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == len_q) ? DONE : RD;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_relu_sram_sweeper.sv
// Directed bench for relu_sram_sweeper with a behavioural 1-cycle SRAM.
module tb_relu_sram_sweeper;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_base, dst_base;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW:0]   neg_cnt;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk = 0;
  int n_err = 0;

  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_q[$];

  always #5 clk = ~clk;

  relu_sram_sweeper #(.ADDR_W(AW), .Data_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .neg_cnt    (neg_cnt),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Single-port synchronous SRAM model.
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launch a sweep and observe cycles 1..2n+4; start is re-pulsed in cycles pa/pb.
  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n,
                     input int pa, input int pb,
                     output int done_cyc, output int done_cnt, output int cs_cnt);
    @(negedge clk);
    src_base = s; dst_base = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1; done_cnt = 0; cs_cnt = 0;
    rd_q.delete(); wr_q.delete();
    for (int c = 1; c <= 2 * int'(n) + 4; c++) begin
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        done_cnt++;
      end
      if (sram_cs) begin
        cs_cnt++;
        if (sram_we) wr_q.push_back(sram_addr);
        else         rd_q.push_back(sram_addr);
      end
      start = (c == pa) || (c == pb);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int dc, dn, cc, nz;

  initial begin
    rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h1111;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_neg",  32'(neg_cnt), 0);
    chk("rst_cs",   32'(sram_cs), 0);
    chk("rst_we",   32'(sram_we), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_wdat", 32'(sram_wdata), 0);
    rst_n = 1'b1;

    // In-place basic sweep.
    mem[0] = 16'h0005; mem[1] = 16'h8003; mem[2] = 16'h7FFF; mem[3] = 16'hFFFF;
    run(12'h000, 12'h000, 13'd4, -1, -1, dc, dn, cc);
    chk("t1_m0", 32'(mem[0]), 32'h0005);
    chk("t1_m1", 32'(mem[1]), 32'h0000);
    chk("t1_m2", 32'(mem[2]), 32'h7FFF);
    chk("t1_m3", 32'(mem[3]), 32'h0000);
    chk("t1_neg", 32'(neg_cnt), 2);
    chk("t1_donecyc", 32'(dc), 9);
    chk("t1_donecnt", 32'(dn), 1);
    chk("t1_cscnt", 32'(cc), 8);
    chk("t1_busy_end", 32'(busy), 0);

    // Zero-length sweep.
    run(12'h005, 12'h005, 13'd0, -1, -1, dc, dn, cc);
    chk("t2_donecyc", 32'(dc), 1);
    chk("t2_donecnt", 32'(dn), 1);
    chk("t2_cscnt", 32'(cc), 0);
    chk("t2_neg", 32'(neg_cnt), 0);

    // Source range wraps past the top of the bank.
    mem[12'hFFE] = 16'h1234; mem[12'hFFF] = 16'h9000;
    mem[12'h000] = 16'h0001; mem[12'h001] = 16'hFFFF;
    for (int i = 0; i < 4; i++) mem[12'h100 + i] = 16'hAAAA;
    run(12'hFFE, 12'h100, 13'd4, -1, -1, dc, dn, cc);
    chk("t3_nrd", 32'(rd_q.size()), 4);
    chk("t3_nwr", 32'(wr_q.size()), 4);
    if (rd_q.size() == 4 && wr_q.size() == 4) begin
      chk("t3_rd0", 32'(rd_q[0]), 32'hFFE);
      chk("t3_rd1", 32'(rd_q[1]), 32'hFFF);
      chk("t3_rd2", 32'(rd_q[2]), 32'h000);
      chk("t3_rd3", 32'(rd_q[3]), 32'h001);
      for (int i = 0; i < 4; i++) chk("t3_wr", 32'(wr_q[i]), 32'h100 + 32'(i));
    end
    chk("t3_d0", 32'(mem[12'h100]), 32'h1234);
    chk("t3_d1", 32'(mem[12'h101]), 32'h0000);
    chk("t3_d2", 32'(mem[12'h102]), 32'h0001);
    chk("t3_d3", 32'(mem[12'h103]), 32'h0000);
    chk("t3_s0", 32'(mem[12'hFFE]), 32'h1234);
    chk("t3_s1", 32'(mem[12'hFFF]), 32'h9000);
    chk("t3_s2", 32'(mem[12'h000]), 32'h0001);
    chk("t3_s3", 32'(mem[12'h001]), 32'hFFFF);
    chk("t3_neg", 32'(neg_cnt), 2);
    chk("t3_donecyc", 32'(dc), 9);

    // Starts while busy and during DONE are dropped.
    run(12'h200, 12'h200, 13'd4, 3, 9, dc, dn, cc);
    chk("t4_donecyc", 32'(dc), 9);
    chk("t4_donecnt", 32'(dn), 1);
    chk("t4_cscnt", 32'(cc), 8);
    chk("t4_busy_end", 32'(busy), 0);

    // Reset in the third WR cycle (cycle 6).
    for (int i = 0; i < 4; i++) mem[12'h300 + i] = 16'h8001;
    @(negedge clk);
    src_base = 12'h300; dst_base = 12'h300; len = 13'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_in_wr", 32'({sram_cs, sram_we}), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("t5_cs", 32'(sram_cs), 0);
    chk("t5_we", 32'(sram_we), 0);
    chk("t5_addr", 32'(sram_addr), 0);
    chk("t5_wdat", 32'(sram_wdata), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_neg", 32'(neg_cnt), 0);
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("t5_nodone", 32'(dn), 0);
    rst_n = 1'b1;
    chk("t5_m0", 32'(mem[12'h300]), 32'h0000);
    chk("t5_m1", 32'(mem[12'h301]), 32'h0000);
    chk("t5_m2", 32'(mem[12'h302]), 32'h8001);
    chk("t5_m3", 32'(mem[12'h303]), 32'h8001);
    run(12'h300, 12'h300, 13'd4, -1, -1, dc, dn, cc);
    chk("t5_re_done", 32'(dc), 9);
    chk("t5_re_neg", 32'(neg_cnt), 2);
    chk("t5_re_m2", 32'(mem[12'h302]), 32'h0000);
    chk("t5_re_m3", 32'(mem[12'h303]), 32'h0000);

    // Full-bank sweep of negative zeros.
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h8000;
    run(12'h000, 12'h000, 13'd4096, -1, -1, dc, dn, cc);
    nz = 0;
    for (int i = 0; i < (1 << AW); i++) if (mem[i] != 16'h0000) nz++;
    chk("t6_nonzero", 32'(nz), 0);
    chk("t6_neg", 32'(neg_cnt), 4096);
    chk("t6_donecyc", 32'(dc), 8193);
    chk("t6_donecnt", 32'(dn), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
